// File: rtl/pwm_capture.sv
// PWM period / high-time capture with timeout detection.
// PWM_IN is synchronized, edge-detected and measured in CLK cycles.
module pwm_capture #(
  parameter int unsigned WIDTH       = 28,
  parameter int unsigned TIMEOUT_CYC = 32'd268435455
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PWM_IN,
  input  logic             EN,
  output logic [WIDTH-1:0] PERIOD_OUT,
  output logic [WIDTH-1:0] HIGH_OUT,
  output logic             VALID,
  output logic             NO_SIGNAL
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT_CYC);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic             s1;
  logic             s2;
  logic             d;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hcnt;
  logic             rise;
  logic             tmo;

  assign rise = s2 & ~d;
  // a rise in the same cycle wins over the timeout
  assign tmo  = (cnt == TMO) & ~rise;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      d          <= 1'b0;
      cnt        <= '0;
      hcnt       <= '0;
      PERIOD_OUT <= '0;
      HIGH_OUT   <= '0;
      VALID      <= 1'b0;
      NO_SIGNAL  <= 1'b0;
      state      <= IDLE;
    end else begin
      s1    <= PWM_IN;
      s2    <= s1;
      d     <= s2;
      VALID <= 1'b0;
      if (!EN) begin
        state <= IDLE;
        cnt   <= '0;
        hcnt  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= ARM;
            cnt   <= '0;
            hcnt  <= '0;
          end
          ARM: begin
            unique case (1'b1)
              rise: begin
                state <= MEASURE;
                cnt   <= ONE;
                hcnt  <= ONE;
              end
              tmo: begin
                NO_SIGNAL  <= 1'b1;
                PERIOD_OUT <= '0;
                HIGH_OUT   <= '0;
                cnt        <= '0;
                hcnt       <= '0;
              end
              default: cnt <= cnt + ONE;
            endcase
          end
          MEASURE: begin
            unique case (1'b1)
              rise: begin
                PERIOD_OUT <= cnt;
                HIGH_OUT   <= hcnt;
                VALID      <= 1'b1;
                NO_SIGNAL  <= 1'b0;
                cnt        <= ONE;
                hcnt       <= ONE;
              end
              tmo: begin
                state      <= ARM;
                NO_SIGNAL  <= 1'b1;
                PERIOD_OUT <= '0;
                HIGH_OUT   <= '0;
                cnt        <= '0;
                hcnt       <= '0;
              end
              default: begin
                cnt <= cnt + ONE;
                if (s2) hcnt <= hcnt + ONE;
              end
            endcase
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture.
// Expected events are queued ahead of stimulus; a negedge monitor checks them.
module tb_pwm_capture;

  localparam int W   = 28;
  localparam int TMO = 1000;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         PWM_IN;
  logic         EN;
  logic [W-1:0] PERIOD_OUT;
  logic [W-1:0] HIGH_OUT;
  logic         VALID;
  logic         NO_SIGNAL;

  always #5 CLK = ~CLK;

  pwm_capture #(
    .WIDTH      (W),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .PWM_IN    (PWM_IN),
    .EN        (EN),
    .PERIOD_OUT(PERIOD_OUT),
    .HIGH_OUT  (HIGH_OUT),
    .VALID     (VALID),
    .NO_SIGNAL (NO_SIGNAL)
  );

  // kind 0 = VALID, 1 = timeout; dt/cyc of 0 mean "don't care"
  typedef struct {
    int kind;
    int per;
    int hi;
    int dt;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   last_evt = 0;
  logic v_q      = 1'b0;
  logic ns_q     = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push(int k, int p, int h, int dt, int c);
    sb.push_back('{k, p, h, dt, c});
  endtask

  task automatic stream(int p, int h, int n);
    repeat (n) begin
      PWM_IN = 1'b1;
      step(h);
      PWM_IN = 1'b0;
      step(p - h);
    end
  endtask

  task automatic chk_out(string tag, int p, int h, int ns);
    chk({tag, "_period"}, int'(PERIOD_OUT), p);
    chk({tag, "_high"}, int'(HIGH_OUT), h);
    chk({tag, "_no_signal"}, int'(NO_SIGNAL), ns);
    chk({tag, "_valid"}, int'(VALID), 0);
  endtask

  always @(negedge CLK) begin
    if (VALID === 1'b1 || (NO_SIGNAL === 1'b1 && !ns_q)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: valid=%0b no_signal=%0b, expected none",
                 VALID, NO_SIGNAL);
      end else begin
        e = sb.pop_front();
        chk("ev_kind", (VALID === 1'b1) ? 0 : 1, e.kind);
        chk("ev_period", int'(PERIOD_OUT), e.per);
        chk("ev_high", int'(HIGH_OUT), e.hi);
        chk("ev_no_signal", int'(NO_SIGNAL), e.kind);
        if (e.dt != 0) chk("ev_interval", cyc - last_evt, e.dt);
        if (e.cyc != 0) chk("ev_latency", cyc, e.cyc);
      end
      last_evt = cyc;
    end
    if (VALID === 1'b1 && v_q) begin
      checks++;
      errors++;
      $display("FAIL valid_width: got 2+ cycles, expected 1");
    end
    v_q  = (VALID === 1'b1);
    ns_q = (NO_SIGNAL === 1'b1);
  end

  initial begin
    RST_N  = 1'b0;
    EN     = 1'b0;
    PWM_IN = 1'b0;
    step(1);
    for (int i = 0; i < 3; i++) begin
      PWM_IN = ~PWM_IN;
      step(1);
      chk_out("rst", 0, 0, 0);
    end
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      PWM_IN = ~PWM_IN;
      step(1);
    end
    chk_out("post_rst", 0, 0, 0);
    PWM_IN = 1'b0;
    step(4);

    // steady 100/25, first VALID at the second rise
    EN = 1'b1;
    step(5);
    push(0, 100, 25, 0, cyc + 103);
    push(0, 100, 25, 100, 0);
    push(0, 100, 25, 100, 0);
    stream(100, 25, 4);

    // minimum waveform 2/1
    push(0, 100, 25, 100, 0);
    for (int i = 0; i < 5; i++) push(0, 2, 1, 2, 0);
    stream(2, 1, 6);

    // back to 100/25 then signal loss
    push(0, 2, 1, 2, 0);
    push(0, 100, 25, 100, 0);
    push(1, 0, 0, TMO, 0);
    stream(100, 25, 2);
    step(1100);
    chk_out("timeout", 0, 0, 1);

    // recovery at 50/10
    push(0, 50, 10, 0, 0);
    push(0, 50, 10, 50, 0);
    stream(50, 10, 3);

    // EN dropped mid-period
    push(0, 50, 10, 50, 0);
    for (int i = 0; i < 3; i++) push(0, 100, 25, 100, 0);
    stream(100, 25, 3);
    PWM_IN = 1'b1;
    step(25);
    PWM_IN = 1'b0;
    step(10);
    EN = 1'b0;
    step(65);
    chk_out("en_off", 100, 25, 0);
    stream(100, 25, 2);
    chk_out("en_off_pwm", 100, 25, 0);

    // re-enable: first rise only arms
    EN = 1'b1;
    step(5);
    push(0, 100, 25, 0, 0);
    push(0, 100, 25, 100, 0);
    stream(100, 25, 3);

    // reset mid-period
    push(0, 100, 25, 100, 0);
    PWM_IN = 1'b1;
    step(30);
    PWM_IN = 1'b0;
    step(20);
    RST_N = 1'b0;
    step(1);
    chk_out("mid_rst", 0, 0, 0);
    RST_N = 1'b1;
    step(10);
    push(0, 100, 25, 0, 0);
    push(0, 100, 25, 100, 0);
    stream(100, 25, 3);
    step(10);

    for (int i = 0; i < 200 && sb.size() != 0; i++) step(1);
    chk("pending_events", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter WIDTH, default 28, sets the width of the measurement counters and outputs.
REQ-002 Parameter TIMEOUT_CYC, default 2^28-1, is the number of cycles without a rising edge before NO_SIGNAL asserts; it SHALL be in the range 2 to 2^WIDTH-1.
REQ-003 CLK  in  1  is the single clock; all logic SHALL be on posedge CLK.
REQ-004 RST_N  in  1  is the reset, synchronous and active-low.
REQ-005 PWM_IN  in  1  is the pulse train to measure; it is asynchronous to CLK.
REQ-006 EN  in  1  enables measurement; it is synchronous to CLK.
REQ-007 PERIOD_OUT  out  WIDTH  is the last measured period, in CLK cycles from rising edge to rising edge.
REQ-008 HIGH_OUT  out  WIDTH  is the last measured high time, in CLK cycles.
REQ-009 VALID  out  1  is a one-cycle pulse marking that PERIOD_OUT and HIGH_OUT were just updated.
REQ-010 NO_SIGNAL  out  1  is a level flag meaning a timeout occurred since the last VALID.

Function
REQ-011 PWM_IN SHALL pass through a 2-flop synchronizer (s1, s2) followed by a delay flop d.
REQ-012 Edge detect: rise = s2 & ~d.
REQ-013 The FSM SHALL have three states:
- IDLE: counter cnt = 0.
- ARM: waiting for the first rising edge.
- MEASURE: a period is in progress.
REQ-014 IDLE transitions to ARM when EN=1, and ARM is entered with cnt=0.
REQ-015 In ARM, a rise SHALL transition to MEASURE with cnt<=1 and hcnt<=1, with no VALID pulse.
REQ-016 In ARM with no rise, cnt SHALL increment each cycle.
REQ-017 In MEASURE with no rise, cnt SHALL increment each cycle, and hcnt SHALL increment when s2=1.
REQ-018 In MEASURE, a rise SHALL cause all of the following on the same edge:
- PERIOD_OUT<=cnt and HIGH_OUT<=hcnt.
- VALID<=1 and NO_SIGNAL<=0.
- cnt<=1 and hcnt<=1.
- The FSM stays in MEASURE.
REQ-019 Resulting values: a waveform with P cycles between sampled rises and H sampled-high cycles SHALL yield PERIOD_OUT=P and HIGH_OUT=H.
REQ-020 The minimum measurable waveform is P=2, H=1.
REQ-021 Timeout: if cnt==TIMEOUT_CYC in ARM or MEASURE and there is no rise that cycle, the block SHALL take all of the following actions:
- Set NO_SIGNAL<=1.
- Clear PERIOD_OUT and HIGH_OUT to 0.
- Set cnt<=0.
- Go to ARM, with no VALID pulse.
REQ-022 When a rise coincides with cnt==TIMEOUT_CYC, the rise SHALL take priority and the timeout SHALL not fire.
REQ-023 Counters SHALL never exceed TIMEOUT_CYC, so no wrap-around is possible.
REQ-024 When EN=0 in any state, the next state SHALL be IDLE with cnt and hcnt cleared.
REQ-025 While EN=0, PERIOD_OUT, HIGH_OUT and NO_SIGNAL SHALL hold their values and VALID SHALL be 0.
REQ-026 After EN is re-asserted, the first VALID SHALL come only after two rises.
REQ-027 VALID SHALL be high for exactly one cycle per measured period and low otherwise.
REQ-028 Latency: VALID SHALL assert after the 3rd CLK edge that samples PWM_IN high for the closing rise.
REQ-029 The outputs SHALL be registered and SHALL change only together with VALID or on timeout, reset or EN (per REQ-018, REQ-021, REQ-024, REQ-025 and REQ-030).

Reset
REQ-030 When RST_N=0 at a CLK edge, the following SHALL be cleared to 0: s1, s2, d, cnt, hcnt, PERIOD_OUT, HIGH_OUT, VALID and NO_SIGNAL.
REQ-031 On reset, the state SHALL become IDLE.
REQ-032 Reset SHALL take priority over EN, rise and timeout.
REQ-033 Reset mid-period SHALL discard the partial measurement.
REQ-034 Reset SHALL have no asynchronous effect between CLK edges.

Verification
REQ-035 Reset scenario: RST_N=0 for 3 cycles while PWM_IN toggles -> all outputs 0, no VALID; after release with EN=0 -> outputs remain 0.
REQ-036 Steady PWM scenario: EN=1, PWM_IN period 100 / high 25 -> first VALID at the second rise, then VALID every 100 cycles with PERIOD_OUT=100, HIGH_OUT=25.
REQ-037 Boundary scenario: period 100/25 switched to period 2/high 1 -> VALID every 2 cycles with PERIOD_OUT=2, HIGH_OUT=1.
REQ-038 Timeout scenario: TIMEOUT_CYC=1000, PWM_IN held low after a 100/25 stream -> NO_SIGNAL=1 and outputs 0 exactly when cnt reaches 1000; restarting 50/10 -> NO_SIGNAL=0 at the first VALID, with PERIOD_OUT=50, HIGH_OUT=10.
REQ-039 EN scenario: EN dropped mid-period -> no VALID and outputs hold 100/25; EN re-asserted -> the first VALID occurs at the second rise, not the first.
REQ-040 Mid-period reset scenario: synchronous reset pulsed mid-period -> outputs 0 on that edge, and measurement restarts from IDLE/ARM when EN=1.
